lsu_mem_access: RTL and testbench
=================================

// Module: lsu_mem_access
// PURPOSE
// - Load/store unit in the MEM stage, downstream of the decoder's Load/Store/ChipSel controls.
// - Turns one decoded access into a word-aligned SRAM request with active-low byte write enables (WEB).
// - Returns sign- or zero-extended load data to writeback.
// - Stalls the pipeline until the memory handshake finishes.
// PARAMETERS
// - ADDR_W  32  byte-address width
// - DATA_W  32  data width; fixed at 32, lane logic assumes 4 byte lanes
// PORTS
// - clk          in   1   clock, rising edge
// - rst          in   1   asynchronous, active-high reset
// - req_valid    in   1   MEM-stage instruction valid (ChipSel)
// - req_load     in   3   000 none, 001 LB, 010 LH, 011 LBU, 100 LHU, 101 LW
// - req_store    in   2   00 none, 01 SB, 10 SH, 11 SW
// - req_addr     in   32  byte address (ALU result)
// - req_wdata    in   32  rs2 store data, right-justified
// - req_rd       in   5   load destination register
// - stall        out  1   hold the pipeline (combinational)
// - mem_req      out  1   SRAM request (registered)
// - mem_gnt      in   1   SRAM accepts the request this cycle
// - mem_addr     out  32  {addr[31:2],2'b00}
// - mem_web      out  4   byte write enable, active low; 4'hF = read
// - mem_wdata    out  32  lane-replicated store data
// - mem_rvalid   in   1   read data valid
// - mem_rdata    in   32  read word
// - wb_valid     out  1   one-cycle pulse: load result ready
// - wb_data      out  32  extended load result
// - wb_rd        out  5   destination of wb_data
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, mem_req=0, mem_web=4'hF, mem_addr=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_rd=0.
// - FSM states: IDLE, REQ, WAIT.
// - Access accepted: req_valid && (req_load!=0 || req_store!=0). Load and store both non-zero: treated as a load, store ignored.
// - IDLE + access: latch addr, rd, op, byte offset off=addr[1:0]. Next cycle mem_req=1, state to REQ.
// - REQ: mem_req, mem_addr, mem_web and mem_wdata stay stable until mem_gnt. On gnt, mem_req drops next cycle.
// - REQ exit on gnt: store returns to IDLE; load goes to WAIT.
// - WAIT: on mem_rvalid, extract lane at off and extend; LB/LH sign-extend, LBU/LHU zero-extend. Next cycle wb_valid=1 with wb_data and wb_rd. Return to IDLE.
// - mem_rvalid outside WAIT is ignored.
// - Store lanes (active-low WEB):
//   - SB: WEB = ~(4'b0001<<off), wdata = {4{wdata[7:0]}}
//   - SH: WEB = ~(4'b0011<<{off[1],1'b0}), wdata = {2{wdata[15:0]}}
//   - SW: WEB = 4'h0, wdata unchanged
// - Load lanes: LH/LHU use half off[1]; LW uses the whole word.
// - stall = (IDLE & access) | (REQ & ~(store & gnt)) | (WAIT & ~rvalid). It drops in the completing cycle, so the pipeline advances on that edge.
// - Latency: store min 2 cycles (accept, gnt). Load min 3 cycles to rvalid, plus 1 cycle to wb_valid.
// - Back-to-back: a new access presented in the cycle after completion is accepted from IDLE without a bubble beyond the latency above.
// CONFIGURATION
// - LSU_MISALIGN_TRAP_EN defined:
//   - Adds output misalign 1, a registered one-cycle pulse.
//   - Raised for LH/LHU/SH with off[0]=1, or LW/SW with off!=0.
//   - The access is dropped: no mem_req, no wb_valid. stall is high for the accept cycle only.
// - LSU_MISALIGN_TRAP_EN undefined:
//   - No misalign port.
//   - Low offset bits are force-aligned: half uses off[1], word ignores off.
// TESTING
// - SW addr 0x104, wdata 0xDEADBEEF, gnt on first REQ cycle -> mem_addr 0x104, web 4'h0, stall high exactly 1 cycle.
// - SB addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, web 4'b0111, mem_wdata 0xA5A5A5A5.
// - LB addr 0x11, rdata 0x0080FF00 -> wb_data 0xFFFFFFFF. LBU -> 0x000000FF. LH at addr 0x12 -> 0x00000080.
// - Load with gnt delayed 3 cycles and rvalid 2 further -> mem_req and address stable throughout, stall held, single wb_valid pulse.
// - rst asserted in WAIT -> mem_req=0, web=4'hF, wb_valid never pulses. The next load completes normally.
// - With LSU_MISALIGN_TRAP_EN, LW addr 0x102 -> misalign pulse, mem_req stays 0.

Source files
------------

// File: rtl/lsu_mem_access.sv
// lsu_mem_access
//   MEM-stage load/store unit. One decoded access is turned into a
//   word-aligned SRAM request with active-low byte write enables. Load data
//   comes back sign- or zero-extended to writeback. The pipeline is stalled
//   until the memory handshake completes.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> adds output 'misalign'. This is a registered one-cycle
//                pulse, and the misaligned access is dropped.
//   undefined -> misaligned halves and words are force-aligned.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   req_valid             MEM-stage instruction valid (chip select)
//   req_load  [2:0]       000 none, 001 LB, 010 LH, 011 LBU, 100 LHU, 101 LW
//   req_store [1:0]       00 none, 01 SB, 10 SH, 11 SW
//   req_addr, req_wdata   byte address and right-justified store data
//   req_rd    [4:0]       load destination register
//   stall                 combinational pipeline hold
//   mem_req/gnt           SRAM request handshake (mem_req is registered)
//   mem_addr/web/wdata    word address, active-low byte enables, lane data
//   mem_rvalid/rdata      SRAM read return
//   wb_valid/data/rd      one-cycle load result pulse to writeback
//   misalign              (macro only) misaligned-access pulse
module lsu_mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_load,
  input  logic [1:0]        req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_web,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd
`ifdef LSU_MISALIGN_TRAP_EN
  ,output logic             misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, next_state;

  logic              access;
  logic              misaligned;
  logic [1:0]        off_in;
  logic [3:0]        lane_web;
  logic [DATA_W-1:0] lane_wdata;

  logic [2:0]        cur_load;
  logic [1:0]        cur_off;
  logic [4:0]        cur_rd;
  logic              cur_is_load;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_ext;

  // A load takes priority over a store when both controls are non-zero.
  assign access      = req_valid && ((req_load != 3'd0) || (req_store != 2'd0));
  assign off_in      = req_addr[1:0];
  assign cur_is_load = (cur_load != 3'd0);

`ifdef LSU_MISALIGN_TRAP_EN
  // Halves need off[0]=0 and words need off=0. Encodings 110/111 behave as LW.
  always_comb begin
    misaligned = 1'b0;
    if (req_load != 3'd0) begin
      case (req_load)
        3'd1, 3'd3: misaligned = 1'b0;
        3'd2, 3'd4: misaligned = off_in[0];
        default:    misaligned = |off_in;
      endcase
    end else begin
      case (req_store)
        2'd2:    misaligned = off_in[0];
        2'd3:    misaligned = |off_in;
        default: misaligned = 1'b0;
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store lane steering. Halves use only off[1] and words ignore the offset,
  // which gives the force-alignment behaviour. A load is always a read (web=F).
  always_comb begin
    lane_web   = 4'hF;
    lane_wdata = req_wdata;
    if (req_load == 3'd0) begin
      case (req_store)
        2'd1: begin
          lane_web   = ~(4'b0001 << off_in);
          lane_wdata = {4{req_wdata[7:0]}};
        end
        2'd2: begin
          lane_web   = ~(4'b0011 << {off_in[1], 1'b0});
          lane_wdata = {2{req_wdata[15:0]}};
        end
        2'd3: begin
          lane_web   = 4'h0;
          lane_wdata = req_wdata;
        end
        default: begin
          lane_web   = 4'hF;
          lane_wdata = req_wdata;
        end
      endcase
    end
  end

  // Lane extraction and extension of the returned read word.
  always_comb begin
    case (cur_off)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = cur_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (cur_load)
      3'd1:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd3:    load_ext = {24'd0, byte_sel};
      3'd4:    load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. A dropped misaligned access never leaves IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (access && !misaligned) next_state = REQ;
      REQ:  if (mem_gnt) next_state = cur_is_load ? WAIT : IDLE;
      WAIT: if (mem_rvalid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stall logic. Stall drops in the completing cycle so the pipeline
  // advances on the same edge on which the FSM returns to IDLE.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = access;
      REQ:     stall = !(!cur_is_load && mem_gnt);
      WAIT:    stall = !mem_rvalid;
      default: stall = 1'b0;
    endcase
  end

  // Request and writeback registers. The request fields are captured once at
  // accept and stay stable until the grant arrives. Write enables go back to
  // read after the grant so that no stale write strobe lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_web   <= 4'hF;
      mem_wdata <= '0;
      cur_load  <= 3'd0;
      cur_off   <= 2'd0;
      cur_rd    <= 5'd0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= 5'd0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (access && !misaligned) begin
            mem_req   <= 1'b1;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_web   <= lane_web;
            mem_wdata <= lane_wdata;
            cur_load  <= req_load;
            cur_off   <= off_in;
            cur_rd    <= req_rd;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_web <= 4'hF;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_data  <= load_ext;
            wb_rd    <= cur_rd;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // A misaligned access pulses the trap for one cycle and is otherwise dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= (state == IDLE) && access && misaligned;
  end
`endif

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access
//   Bench for lsu_mem_access. It applies a table of directed accesses, then
//   hand-written reset and misalign sequences, then random accesses with
//   random grant/rvalid latencies. Randomly generated accesses are checked
//   against a byte-level reference model. A scoreboard checks the writeback
//   pulses.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_load;
  logic [1:0]  req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [3:0]  mem_web;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  load;
    logic [1:0]  store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_d;
    int          rv_d;
    logic [31:0] exp_addr;
    logic [3:0]  exp_web;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  wb_t  wb_q[$];
  vec_t vecs[$];

  lsu_mem_access dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_web(mem_web), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd)
`ifdef LSU_MISALIGN_TRAP_EN
    ,.misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  // Watchdog timer.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Writeback scoreboard. An entry is pushed during the cycle in which the
  // pulse is due. Any pulse without a pending entry is an error.
  always @(negedge clk) begin
    wb_t w;
    if (!rst) begin
      if (wb_q.size() > 0) begin
        w = wb_q.pop_front();
        checkOutput("wb_valid", {31'd0, wb_valid}, 32'd1);
        checkOutput("wb_data", wb_data, w.data);
        checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
      end else if (wb_valid) begin
        checkOutput("wb_valid_spurious", {31'd0, wb_valid}, 32'd0);
      end
    end
  end

  // Reference model built from byte ranges. An access of 'size' bytes
  // covers bytes [start, start+size) of the word, where start is the byte
  // offset rounded down to a multiple of size.
  function automatic void model(input logic [2:0] load, input logic [1:0] store,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata,
                                output logic [31:0] e_addr, output logic [3:0] e_web,
                                output logic [31:0] e_wdata, output logic [31:0] e_wb);
    int     size;
    int     start;
    bit     sgn;
    longint v;
    e_addr  = addr & 32'hFFFF_FFFC;
    e_web   = 4'hF;
    e_wdata = 32'd0;
    e_wb    = 32'd0;
    if (load != 3'd0) begin
      case (load)
        3'd1:    begin size = 1; sgn = 1; end
        3'd2:    begin size = 2; sgn = 1; end
        3'd3:    begin size = 1; sgn = 0; end
        3'd4:    begin size = 2; sgn = 0; end
        default: begin size = 4; sgn = 0; end
      endcase
      start = (int'(addr[1:0]) / size) * size;
      v = 0;
      for (int k = 0; k < size; k++)
        v = v + (longint'(rdata[8*(start+k) +: 8]) << (8*k));
      if (sgn && v >= (longint'(1) << (8*size - 1)))
        v = v - (longint'(1) << (8*size));
      e_wb = v[31:0];
    end else if (store != 2'd0) begin
      size  = (store == 2'd1) ? 1 : (store == 2'd2) ? 2 : 4;
      start = (int'(addr[1:0]) / size) * size;
      for (int i = 0; i < 4; i++) begin
        e_web[i] = !(i >= start && i < start + size);
        e_wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
    end
  endfunction

  // Presents one access and acts as the SRAM. Checks run on every cycle of
  // the access. The caller may start the next access immediately.
  task automatic applyStimulus(input logic [2:0] load, input logic [1:0] store,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [4:0] rd,
                               input int gnt_d, input int rv_d, input bit noise,
                               input logic [31:0] e_addr, input logic [3:0] e_web,
                               input logic [31:0] e_wdata, input logic [31:0] e_wb);
    bit  is_load;
    wb_t w;
    is_load   = (load != 3'd0);
    req_valid = 1'b1;
    req_load  = load;
    req_store = store;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    mem_gnt   = 1'b0;
    mem_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata  = $urandom;
    @(negedge clk);
    checkOutput("accept_stall", {31'd0, stall}, 32'd1);
    checkOutput("accept_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    for (int g = 0; g <= gnt_d; g++) begin
      mem_gnt = (g == gnt_d);
      if (noise) begin
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
      end
      @(negedge clk);
      checkOutput("req_mem_req", {31'd0, mem_req}, 32'd1);
      checkOutput("req_mem_addr", mem_addr, e_addr);
      checkOutput("req_mem_web", {28'd0, mem_web}, {28'd0, e_web});
      if (!is_load) checkOutput("req_mem_wdata", mem_wdata, e_wdata);
      checkOutput("req_stall", {31'd0, stall}, {31'd0, (is_load || g != gnt_d)});
      @(posedge clk); #1;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (is_load) begin
      for (int r = 0; r <= rv_d; r++) begin
        mem_rvalid = (r == rv_d);
        mem_rdata  = (r == rv_d) ? rdata : $urandom;
        @(negedge clk);
        checkOutput("wait_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("wait_stall", {31'd0, stall}, {31'd0, (r != rv_d)});
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      w.data = e_wb;
      w.rd   = rd;
      wb_q.push_back(w);
    end
    req_valid = 1'b0;
    req_load  = 3'd0;
    req_store = 2'd0;
  endtask

  task automatic idle_cycle();
    req_valid = 1'($urandom_range(0, 1));
    req_load  = 3'd0;
    req_store = 2'd0;
    @(negedge clk);
    checkOutput("idle_stall", {31'd0, stall}, 32'd0);
    checkOutput("idle_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ea, ewd, ewb;
    logic [3:0]  eweb;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] ad;

    // Directed vectors: {load, store, addr, wdata, rdata, gnt_d, rv_d, exp_addr, exp_web, exp_wdata, exp_wb}.
    vecs.push_back('{3'd0, 2'd3, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 32'h104, 4'h0, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{3'd0, 2'd1, 32'h203, 32'h000000A5, 32'h0, 1, 0, 32'h200, 4'b0111, 32'hA5A5A5A5, 32'h0});
    vecs.push_back('{3'd1, 2'd0, 32'h11, 32'h0, 32'h0080FF00, 0, 0, 32'h10, 4'hF, 32'h0, 32'hFFFFFFFF});
    vecs.push_back('{3'd3, 2'd0, 32'h11, 32'h0, 32'h0080FF00, 0, 0, 32'h10, 4'hF, 32'h0, 32'h000000FF});
    vecs.push_back('{3'd2, 2'd0, 32'h12, 32'h0, 32'h0080FF00, 0, 1, 32'h10, 4'hF, 32'h0, 32'h00000080});
    vecs.push_back('{3'd4, 2'd0, 32'h10, 32'h0, 32'h1234ABCD, 1, 0, 32'h10, 4'hF, 32'h0, 32'h0000ABCD});
    vecs.push_back('{3'd5, 2'd0, 32'h20, 32'h0, 32'hCAFEF00D, 3, 2, 32'h20, 4'hF, 32'h0, 32'hCAFEF00D});
    vecs.push_back('{3'd0, 2'd2, 32'h32, 32'h0000BEEF, 32'h0, 0, 0, 32'h30, 4'b0011, 32'hBEEFBEEF, 32'h0});
    vecs.push_back('{3'd3, 2'd3, 32'h43, 32'h55555555, 32'h7F000000, 0, 0, 32'h40, 4'hF, 32'h0, 32'h0000007F});
    vecs.push_back('{3'd2, 2'd0, 32'h16, 32'h0, 32'h80010000, 2, 0, 32'h14, 4'hF, 32'h0, 32'hFFFF8001});
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{3'd5, 2'd0, 32'h102, 32'h0, 32'h11223344, 0, 0, 32'h100, 4'hF, 32'h0, 32'h11223344});
    vecs.push_back('{3'd0, 2'd2, 32'h201, 32'h00001234, 32'h0, 0, 0, 32'h200, 4'hC, 32'h12341234, 32'h0});
`endif

    rst = 1'b1;
    req_valid = 1'b0; req_load = 3'd0; req_store = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #3;
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_web", {28'd0, mem_web}, 32'hF);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    // Directed table. The loads are back to back with the previous access.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].load, vecs[i].store, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, 5'(i + 1), vecs[i].gnt_d, vecs[i].rv_d, 1'b0,
                    vecs[i].exp_addr, vecs[i].exp_web, vecs[i].exp_wdata, vecs[i].exp_wb);
    end
    idle_cycle();

    // Reset asserted while the FSM waits for rvalid.
    req_valid = 1'b1; req_load = 3'd5; req_store = 2'd0; req_addr = 32'h50; req_rd = 5'd9;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rstwait_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rstwait_mem_web", {28'd0, mem_web}, 32'hF);
    checkOutput("rstwait_wb_valid", {31'd0, wb_valid}, 32'd0);
    req_valid = 1'b0; req_load = 3'd0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    checkOutput("rstwait_wb_valid2", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    applyStimulus(3'd1, 2'd0, 32'h63, 32'h0, 32'h80000000, 5'd7, 1, 1, 1'b0,
                  32'h60, 4'hF, 32'h0, 32'hFFFFFF80);
    idle_cycle();

`ifdef LSU_MISALIGN_TRAP_EN
    // A misaligned LW is dropped and reported with a single pulse.
    req_valid = 1'b1; req_load = 3'd5; req_store = 2'd0; req_addr = 32'h102;
    @(negedge clk);
    checkOutput("mis_stall", {31'd0, stall}, 32'd1);
    checkOutput("mis_pulse_early", {31'd0, misalign}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_load = 3'd0;
    @(negedge clk);
    checkOutput("mis_pulse", {31'd0, misalign}, 32'd1);
    checkOutput("mis_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("mis_stall_after", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mis_pulse_end", {31'd0, misalign}, 32'd0);
    checkOutput("mis_mem_req2", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
`endif

    // Random accesses with random latencies, stray rvalid and gaps.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle();
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          ld = 3'd0;
          st = 2'($urandom_range(1, 3));
        end else begin
          ld = 3'($urandom_range(1, 5));
          st = 2'($urandom_range(0, 3));
        end
        ad = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
        if (ld == 3'd5 || (ld == 3'd0 && st == 2'd3)) ad[1:0] = 2'b00;
        else if (ld == 3'd2 || ld == 3'd4 || (ld == 3'd0 && st == 2'd2)) ad[0] = 1'b0;
`endif
        req_wdata = $urandom;
        mem_rdata = $urandom;
        model(ld, st, ad, req_wdata, mem_rdata, ea, eweb, ewd, ewb);
        applyStimulus(ld, st, ad, req_wdata, mem_rdata, 5'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b1, ea, eweb, ewd, ewb);
      end
    end
    idle_cycle();
    idle_cycle();
    checkOutput("wb_queue_empty", wb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
